// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared fetch-stage types and constants
package sys_defs;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fq_entry_t;

    typedef enum logic {
        IF_RUN,
        IF_DRAIN
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch stage bundle: control inputs, imem channels, IF/ID register
interface if_stage_if;
    logic        id_stall_flag;
    logic        ex_take_branch;
    logic [31:0] ex_target_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] if_id_IR;
    logic [31:0] if_id_PC;
    logic        if_id_valid_inst;

    modport master (
        input  id_stall_flag, ex_take_branch, ex_target_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_req_addr,
        output if_id_IR, if_id_PC, if_id_valid_inst
    );

    modport slave (
        output id_stall_flag, ex_take_branch, ex_target_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_req_addr,
        input  if_id_IR, if_id_PC, if_id_valid_inst
    );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - power-of-2 FIFO of fetched instructions; flush beats push
module if_fetch_queue
    import sys_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fq_entry_t              wdata,
    input  logic                   pop,
    input  logic                   flush,
    output fq_entry_t              rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_en, pop_en;

    assign pop_en  = pop && (cnt_q != '0);
    assign push_en = push && ((cnt_q != FULL_C) || pop_en);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            wr_d  = wr_q + AW'(push_en);
            rd_d  = rd_q + AW'(pop_en);
            cnt_d = cnt_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !flush) begin
            mem_q[wr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;

    // The fetch credit limit makes a push into a full, non-popping queue impossible.
    assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && !pop_en && (cnt_q == FULL_C)));

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32 instruction fetch stage feeding IF/ID
// Optional IF_PERF_CNT_EN adds saturating fetched/bubble counters.
module if_stage
    import sys_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);
    localparam int          CW      = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

    logic [31:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;
    fetch_state_e state_q, state_d;
    logic [31:0]  if_id_ir_q, if_id_ir_d, if_id_pc_q, if_id_pc_d;
    logic         if_id_vld_q, if_id_vld_d;

    logic [CW-1:0] fq_count;
    fq_entry_t     fq_head, fq_wdata;
    logic          fq_push, fq_pop, fq_flush;
    logic [CW:0]   credit_used;
    logic          req_valid, accept;

    assign credit_used = {1'b0, outst_q} + {1'b0, fq_count};
    assign req_valid   = rst && !bus.ex_take_branch && (credit_used < DEPTH_C);
    assign accept      = req_valid && bus.imem_req_ready;

    always_comb begin
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        if_id_ir_d  = if_id_ir_q;
        if_id_pc_d  = if_id_pc_q;
        if_id_vld_d = if_id_vld_q;
        fq_push     = 1'b0;
        fq_pop      = 1'b0;
        fq_flush    = 1'b0;
        fq_wdata.ir = bus.imem_rsp_data;
        fq_wdata.pc = rsp_pc_q;
        if (bus.ex_take_branch) begin
            pc_d        = align_pc(bus.ex_target_pc);
            rsp_pc_d    = align_pc(bus.ex_target_pc);
            fq_flush    = 1'b1;
            if_id_ir_d  = NOP_INST;
            if_id_vld_d = 1'b0;
            // outstanding already includes any pending drops, so every remaining response is stale
            outst_d     = outst_q - CW'(bus.imem_rsp_valid);
            drop_d      = outst_q - CW'(bus.imem_rsp_valid);
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            outst_d = outst_q + CW'(accept) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid) begin
                if (state_q == IF_DRAIN) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    fq_push  = 1'b1;
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end
            if (!bus.id_stall_flag) begin
                if (fq_count != '0) begin
                    fq_pop      = 1'b1;
                    if_id_ir_d  = fq_head.ir;
                    if_id_pc_d  = fq_head.pc;
                    if_id_vld_d = 1'b1;
                end else begin
                    if_id_ir_d  = NOP_INST;
                    if_id_vld_d = 1'b0;
                end
            end
        end
        state_d = (drop_d != '0) ? IF_DRAIN : IF_RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            state_q     <= IF_RUN;
            if_id_ir_q  <= NOP_INST;
            if_id_pc_q  <= 32'h0;
            if_id_vld_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            state_q     <= state_d;
            if_id_ir_q  <= if_id_ir_d;
            if_id_pc_q  <= if_id_pc_d;
            if_id_vld_q <= if_id_vld_d;
        end
    end

    if_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (fq_push),
        .wdata (fq_wdata),
        .pop   (fq_pop),
        .flush (fq_flush),
        .rdata (fq_head),
        .count (fq_count)
    );

    assign bus.imem_req_valid   = req_valid;
    assign bus.imem_req_addr    = pc_q;
    assign bus.if_id_IR         = if_id_ir_q;
    assign bus.if_id_PC         = if_id_pc_q;
    assign bus.if_id_valid_inst = if_id_vld_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_bubbles_q, perf_bubbles_d;
    logic        if_load;

    assign if_load = bus.ex_take_branch || !bus.id_stall_flag;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        if (if_load && if_id_vld_d && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (if_load && !if_id_vld_d && !bus.id_stall_flag && (perf_bubbles_q != '1)) begin
            perf_bubbles_d = perf_bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized scoreboard bench for if_stage
module tb_if_stage;
    import sys_defs::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_stage_if bus();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    if_stage #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    mreq_t mem_q[$];
    exp_t  exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int last_due = -1;
    int epoch = 0;
    int m_out = 0;
    int m_buf = 0;
    logic [31:0] m_pc = RESET_PC;
    bit mon_en = 1'b0;
    bit nxt_br, nxt_stall, nxt_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F01;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus the reference model's view of the edge that ends it.
    task automatic cycle(input bit stall, input bit br, input logic [31:0] tgt, input bit rdy);
        mreq_t m;
        bit    rsp_now, rsp_live, exp_req;
        int    due;
        @(negedge clk);
        bus.id_stall_flag  = stall;
        bus.ex_take_branch = br;
        bus.ex_target_pc   = tgt;
        bus.imem_req_ready = rdy;
        rsp_now  = 1'b0;
        rsp_live = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(m.addr);
            rsp_now  = 1'b1;
            rsp_live = (m.epoch == epoch);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        exp_req = !br && (m_out + m_buf < FQ_DEPTH);
        chk("req_valid", bus.imem_req_valid, exp_req);
        if (exp_req) chk("req_addr", bus.imem_req_addr, m_pc);
        if (bus.imem_req_valid && rdy) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{bus.imem_req_addr, due, epoch});
        end
        nxt_br    = br;
        nxt_stall = stall;
        nxt_pop   = !br && !stall && (m_buf > 0);
        mon_en    = 1'b1;
        if (exp_req && rdy) begin
            exp_q.push_back('{mem_word(m_pc), m_pc});
            m_pc  = m_pc + 32'd4;
            m_out = m_out + 1;
        end
        if (rsp_now) m_out = m_out - 1;
        if (br) begin
            exp_q.delete();
            m_buf = 0;
            m_pc  = tgt & 32'hFFFF_FFFC;
            epoch = epoch + 1;
        end else begin
            m_buf = m_buf + (rsp_live ? 1 : 0) - (nxt_pop ? 1 : 0);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 32'd0);
        chk("rst_valid", bus.if_id_valid_inst, 32'd0);
        chk("rst_ir", bus.if_id_IR, NOP_INST);
        chk("rst_pc", bus.if_id_PC, 32'd0);
        mem_q.delete();
        exp_q.delete();
        m_pc     = RESET_PC;
        m_out    = 0;
        m_buf    = 0;
        last_due = -1;
        epoch    = epoch + 1;
        bus.id_stall_flag  = 1'b0;
        bus.ex_take_branch = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc++;
    endtask

    task automatic rand_cycle();
        if ($urandom_range(0, 31) == 0) lat = $urandom_range(1, 4);
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom,
              $urandom_range(0, 9) < 7);
    endtask

    // Monitor: the IF/ID register as seen after each edge, against the scoreboard.
    logic [31:0] h_ir, h_pc;
    logic        h_vld;
    always @(negedge clk) begin
        if (!mon_en) begin
            h_ir  = NOP_INST;
            h_pc  = 32'h0;
            h_vld = 1'b0;
        end else begin
            if (nxt_br) begin
                h_ir  = NOP_INST;
                h_vld = 1'b0;
            end else if (nxt_stall) begin
                h_vld = h_vld;
            end else if (nxt_pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got empty scoreboard expected an entry (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    h_ir = e.ir;
                    h_pc = e.pc;
                end
                h_vld = 1'b1;
            end else begin
                h_ir  = NOP_INST;
                h_vld = 1'b0;
            end
            chk("if_id_valid", bus.if_id_valid_inst, h_vld);
            chk("if_id_ir", bus.if_id_IR, h_ir);
            chk("if_id_pc", bus.if_id_PC, h_pc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst                = 1'b0;
        bus.id_stall_flag  = 1'b0;
        bus.ex_take_branch = 1'b0;
        bus.ex_target_pc   = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        do_reset();

        lat = 1;
        repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3)  cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (12) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        lat = 3;
        repeat (6)  cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        lat = 1;
        repeat (4)  cycle(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFF6, 1'b1);
        repeat (12) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 500; i++) rand_cycle();

        do_reset();
        lat = 1;
        repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 300; i++) rand_cycle();

        repeat (16) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("memory_drained", mem_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
